// File: rtl/uart_pkg.sv
// Shared UART definitions: buffer FSM encodings and default widths
// used by the transmit and receive side byte buffers.
package uart_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] TXB_IDLE = 2'b00;
  localparam logic [1:0] TXB_WAIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = TXB_IDLE,
    ST_WAIT = TXB_WAIT
  } txb_state_t;

  function automatic logic [ADDR_W_DEF:0] depth_of(input int aw);
    return (ADDR_W_DEF+1)'(1 << aw);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular byte FIFO with occupancy count; head is mem[r_ptr], unregistered.
// UART_TXBUF_LEVEL_EN adds the level output.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] head,
  output logic            full,
  output logic            empty,
  output logic            overflow
`ifdef UART_TXBUF_LEVEL_EN
  ,
  output logic [ADDR_W:0] level
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   count;
  logic              we;
  logic              re;

  assign full     = count == (ADDR_W+1)'(DEPTH);
  assign empty    = count == '0;
  assign overflow = wr && full;
  assign head     = mem[r_ptr];

  // full blocks the write even when a pop lands in the same cycle
  assign we = wr && !full;
  assign re = rd && !empty;

`ifdef UART_TXBUF_LEVEL_EN
  assign level = count;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (we) w_ptr <= w_ptr + 1'b1;
      if (re) r_ptr <= r_ptr + 1'b1;
      unique case ({we, re})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Transmit byte buffer: queues host bytes and launches them one frame
// at a time. UART_TXBUF_LEVEL_EN exposes the FIFO occupancy on level.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            busy,
  output logic            tx_start,
  output logic [DBIT-1:0] din,
  input  logic            tx_done_tick
`ifdef UART_TXBUF_LEVEL_EN
  ,
  output logic [ADDR_W:0] level
`endif
);

  txb_state_t      state;
  txb_state_t      state_next;
  logic            start_next;
  logic            rd;
  logic [DBIT-1:0] head;

  uart_fifo #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef UART_TXBUF_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  assign busy = (state != ST_IDLE) || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      din      <= '0;
    end else begin
      state    <= state_next;
      tx_start <= start_next;
      if (rd) din <= head;
    end
  end

  // pop only when leaving IDLE; done ticks outside WAIT are ignored
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    rd         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          rd         = 1'b1;
          start_next = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf with a behavioural transmitter
// and a queue-based reference of accepted and launched bytes.
module tb_uart_tx_buf;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       busy;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_done_tick;
`ifdef UART_TXBUF_LEVEL_EN
  logic [4:0] level;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       tx_done_m;
  logic       spur;
  bit         tx_en;
  int         frame_len;
  bit         in_frame;
  int         remain;
  int         bad_start;
  logic [7:0] log_q[$];
  int         start_q[$];
  int         done_q[$];

  assign tx_done_tick = tx_done_m | spur;

  uart_tx_buf dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .busy         (busy),
    .tx_start     (tx_start),
    .din          (din),
    .tx_done_tick (tx_done_tick)
`ifdef UART_TXBUF_LEVEL_EN
    ,
    .level        (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // transmitter model: one frame per launch, done after frame_len cycles
  initial begin
    tx_done_m = 1'b0;
    in_frame  = 1'b0;
    remain    = 0;
    bad_start = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        in_frame  = 1'b0;
        tx_done_m = 1'b0;
      end else begin
        if (tx_done_tick) in_frame = 1'b0;
        tx_done_m = 1'b0;
        if (tx_start) begin
          if (in_frame) bad_start++;
          else begin
            log_q.push_back(din);
            start_q.push_back(cyc);
            in_frame = 1'b1;
            remain   = frame_len;
          end
        end else if (in_frame && tx_en) begin
          remain--;
          if (remain <= 0) begin
            tx_done_m = 1'b1;
            done_q.push_back(cyc);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr    = 1'b0;
    spur  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    log_q.delete();
    start_q.delete();
    done_q.delete();
    bad_start = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr = 1'b0; w_data = '0; spur = 1'b0;
    tx_en = 1'b1; frame_len = 4;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", din); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`ifdef UART_TXBUF_LEVEL_EN
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single();
    int fall;
    do_reset();
    tx_en = 1'b1; frame_len = 4;
    wr = 1'b1; w_data = 8'hA5;
    tick();
    wr = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_wr got %b want 0", empty); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b want 0", tx_start); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
    checks++; if (din !== 8'hA5) begin errors++; $display("FAIL single_din got %h want a5", din); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b want 1", empty); end
    fall = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!busy) begin fall = cyc; break; end
    end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_q.size()); end
    checks++; if (fall !== (done_q.size() > 0 ? done_q[0] + 1 : -2)) begin errors++; $display("FAIL single_busy_fall got %0d want %0d", fall, done_q.size() > 0 ? done_q[0] + 1 : -2); end
    checks++; if (din !== 8'hA5) begin errors++; $display("FAIL single_din_hold got %h want a5", din); end
  endtask

  task automatic test_burst();
    int n;
    do_reset();
    tx_en = 1'b1; frame_len = 6;
    for (int i = 1; i <= 5; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
    end
    wr = 1'b0;
    for (n = 0; n < 300 && !(log_q.size() == 5 && !busy); n++) tick();
    checks++; if (n >= 300) begin errors++; $display("FAIL burst_timeout got %0d frames want 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_din[%0d] got %h want %h", i, log_q[i], 8'(i + 1)); end
    end
    for (int i = 1; i < start_q.size() && i <= done_q.size(); i++) begin
      checks++; if (start_q[i] - done_q[i-1] !== 2) begin errors++; $display("FAIL burst_gap[%0d] got %0d want 2", i, start_q[i] - done_q[i-1]); end
    end
    checks++; if (bad_start !== 0) begin errors++; $display("FAIL burst_extra_start got %0d want 0", bad_start); end
  endtask

  task automatic test_full_overflow();
    int n;
    do_reset();
    tx_en = 1'b0; frame_len = 3;
    wr = 1'b1; w_data = 8'hEE;
    tick();
    wr = 1'b0;
    tick();
    tick();
    for (int i = 0; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(8'h10 + i);
      #1;
      checks++; if (overflow !== (i == 16)) begin errors++; $display("FAIL full_overflow[%0d] got %b want %b", i, overflow, i == 16); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL full_flag[%0d] got %b want %b", i, full, i == 16); end
      tick();
    end
    wr = 1'b0;
    tx_en = 1'b1;
    for (n = 0; n < 1000 && busy; n++) tick();
    checks++; if (n >= 1000) begin errors++; $display("FAIL full_drain_timeout got busy want idle"); end
    checks++; if (log_q.size() !== 17) begin errors++; $display("FAIL full_frames got %0d want 17", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== (i == 0 ? 8'hEE : 8'(8'h0F + i))) begin errors++; $display("FAIL full_din[%0d] got %h want %h", i, log_q[i], i == 0 ? 8'hEE : 8'(8'h0F + i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty_end got %b want 1", empty); end
  endtask

  task automatic test_simul();
    int n;
    logic [7:0] exp [5];
    do_reset();
    tx_en = 1'b0; frame_len = 2;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = 8'(8'h30 + i);
      tick();
    end
    wr = 1'b0;
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    wr = 1'b1; w_data = 8'h34;
    tick();
    wr = 1'b0;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL simul_start got %b want 1", tx_start); end
    checks++; if (din !== 8'h31) begin errors++; $display("FAIL simul_din got %h want 31", din); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL simul_flags got e%b f%b want e0 f0", empty, full); end
`ifdef UART_TXBUF_LEVEL_EN
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL simul_level got %0d want 3", level); end
`endif
    tx_en = 1'b1;
    for (n = 0; n < 500 && busy; n++) tick();
    checks++; if (log_q.size() !== 5) begin errors++; $display("FAIL simul_frames got %0d want 5", log_q.size()); end
    for (int i = 0; i < 5; i++) exp[i] = 8'(8'h30 + i);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL simul_din[%0d] got %h want %h", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int size0;
    do_reset();
    tx_en = 1'b0; frame_len = 3;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'(8'h40 + i);
      tick();
    end
    wr = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL midrst_pre got b%b e%b want b1 e0", busy, empty); end
    reset = 1'b1;
    #1;
    checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async got e%b b%b want e1 b0", empty, busy); end
    checks++; if (din !== 8'h00 || tx_start !== 1'b0) begin errors++; $display("FAIL midrst_regs got din %h start %b want 00 0", din, tx_start); end
    tick();
    reset = 1'b0;
    tx_en = 1'b1;
    size0 = log_q.size();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (log_q.size() !== size0) begin errors++; $display("FAIL midrst_relaunch got %0d frames want %0d", log_q.size(), size0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
  endtask

  task automatic test_spurious_done();
    do_reset();
    tx_en = 1'b1; frame_len = 3;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spur_state got start %b busy %b want 0 0", tx_start, busy); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL spur_launch got %0d frames want 0", log_q.size()); end
    wr = 1'b1; w_data = 8'h77;
    tick();
    wr = 1'b0;
    tick();
    checks++; if (tx_start !== 1'b1 || din !== 8'h77) begin errors++; $display("FAIL spur_after got start %b din %h want 1 77", tx_start, din); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int acc;
    int occ;
    int n;
    do_reset();
    tx_en = 1'b1; frame_len = 4;
    acc = 0;
    for (int c = 0; c < 600; c++) begin
      occ = acc - log_q.size();
      checks++; if (full !== (occ == 16) || empty !== (occ == 0)) begin errors++; $display("FAIL rand_flags c%0d got f%b e%b want occ %0d", c, full, empty, occ); end
`ifdef UART_TXBUF_LEVEL_EN
      checks++; if (level !== 5'(occ)) begin errors++; $display("FAIL rand_level c%0d got %0d want %0d", c, level, occ); end
`endif
      frame_len = int'($urandom_range(1, 14));
      wr = ($urandom_range(0, 9) < 6);
      w_data = 8'($urandom);
      #1;
      checks++; if (overflow !== (wr && occ == 16)) begin errors++; $display("FAIL rand_overflow c%0d got %b want %b", c, overflow, wr && occ == 16); end
      if (wr && occ < 16) begin
        exp_q.push_back(w_data);
        acc++;
      end
      tick();
    end
    wr = 1'b0;
    for (n = 0; n < 3000 && !(log_q.size() == exp_q.size() && !busy); n++) tick();
    checks++; if (n >= 3000) begin errors++; $display("FAIL rand_timeout got %0d frames want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_din[%0d] got %h want %h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (bad_start !== 0) begin errors++; $display("FAIL rand_extra_start got %0d want 0", bad_start); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_simul();
    test_reset_mid_frame();
    test_spurious_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Transmit-side byte buffer and launch controller sitting directly upstream of the UART transmitter. It accepts bytes from the host side through a write strobe, queues them in a FIFO, and feeds them one at a time to the transmitter with a one-cycle `tx_start` pulse and a stable `din`. It waits for the transmitter's `tx_done_tick` before launching the next byte, so the host can burst-write without tracking frame timing.

## Interface
- `DBIT`, 8: data width in bits. Must be 8 to match the transmitter's `din`.
- `ADDR_W`, 4: FIFO address width. Depth is 2^ADDR_W entries (16 by default).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr` in 1: write strobe; enqueues `w_data` on a rising clock edge.
- `w_data` in DBIT: byte to enqueue.
- `full` out 1: FIFO holds 2^ADDR_W bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `overflow` out 1: one-cycle pulse when `wr` is asserted while `full`.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is not empty.
- `tx_start` out 1: one-cycle launch pulse to the transmitter. Registered.
- `din` out 8: byte to transmit. Registered; held until the next launch.
- `tx_done_tick` in 1: end-of-frame pulse from the transmitter.
- `level` out ADDR_W+1: FIFO occupancy. Present only when `UART_TXBUF_LEVEL_EN` is defined.

## Operation
- FIFO:
  - Circular buffer with `w_ptr`/`r_ptr` (ADDR_W bits, natural wrap) and `count` (ADDR_W+1 bits).
  - `full` is asserted when `count == 2^ADDR_W`; `empty` when `count == 0`. Both are decoded from registered state.
- Write:
  - `wr && !full` stores `w_data` at `w_ptr`, increments `w_ptr`, and increments `count`.
  - `wr && full` drops the byte, leaves pointers and count unchanged, and asserts `overflow` for that cycle. Full blocks the write even if a pop occurs in the same cycle.
- Pop:
  - Occurs only on the IDLE→WAIT transition (see FSM).
  - Loads `din` with `mem[r_ptr]`, increments `r_ptr`, and decrements `count`.
- Simultaneous write and pop with `!full`:
  - Both take effect and `count` is unchanged.
  - There is no bypass path: a byte written into an empty FIFO is never popped in the same cycle.
- FSM states (2-bit):
  - IDLE: if `!empty`, pop, set `tx_start_reg` to 1, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: `tx_start_reg` is 0. On `tx_done_tick`, go to IDLE; otherwise stay in WAIT.
- Ignored inputs:
  - `tx_done_tick` in IDLE is ignored.
  - Spurious `tx_done_tick` pulses are not counted.
- Reset values (asynchronous, immediate):
  - State is IDLE; pointers and count are 0.
  - `tx_start=0`, `din=0`, `empty=1`, `full=0`, `overflow=0`, `busy=0`, `level=0`.
  - Reset mid-frame discards all queued bytes. The transmitter shares `reset` and aborts too.

## Timing
- Write latency: after the edge that samples `wr`, `empty` deasserts and `level` increments in the next cycle.
- Launch latency:
  - `tx_start` is high in the cycle after the first edge at which the FSM sees `!empty` in IDLE.
  - For a write into an empty, idle buffer sampled at edge k, `tx_start` is high after edge k+1.
- `din` becomes valid in the same cycle as `tx_start` and stays stable through the whole frame.
- Back-to-back frames:
  - `tx_done_tick` at cycle t moves the FSM to IDLE after edge t.
  - The next `tx_start` is high after edge t+1.
  - The transmitter is already in its idle state in that cycle, so the pulse is accepted.
- `tx_start` is never high for more than one cycle and never high while in WAIT.
- `overflow` is combinational (`wr && full`) from registered `full`.
- `busy` is combinational from registered state.

## Configuration
- `UART_TXBUF_LEVEL_EN` defined: the `level` output port exists and equals `count`.
- Not defined: the port is absent. `count` still exists internally for `full`/`empty`, and all other behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state constants `TXB_IDLE=2'b00` and `TXB_WAIT=2'b01`.
  - Default `DBIT`/`ADDR_W` constants, reused by the receive-side buffer.
- One sub-module, `uart_fifo`: register file, pointers, count, and `full`/`empty`/`overflow`, parameterized by `DBIT`/`ADDR_W`, with a `rd` strobe and registered `r_data`-free head output `mem[r_ptr]`.
- `uart_tx_buf` itself holds the FSM, the `din` register and the `tx_start` register.

## Test plan
- Single byte: `wr` with 0xA5 into an empty buffer → `tx_start` pulses two edges later with `din=0xA5`; `busy` stays high until the FSM is back in IDLE after the model's `tx_done_tick`; `empty=1` after the pop.
- Burst: write 0x01..0x05 back-to-back with a transmitter model → five `tx_start` pulses in order 0x01..0x05, each exactly 2 cycles after the previous `tx_done_tick`.
- Full/overflow (ADDR_W=4): hold the transmitter in WAIT and write 17 bytes (0x10..0x20) → `full` after the 16th byte is accepted; the 17th write pulses `overflow` once and 0x20 is never transmitted.
- Simultaneous write and pop: `wr` in the same cycle the FSM pops, with count=3 → count stays 3 and `level=3` when `UART_TXBUF_LEVEL_EN` is defined.
- Reset mid-frame: assert `reset` while in WAIT with 4 bytes queued → the next cycle shows `empty=1`, `tx_start=0`, `din=0`, `busy=0`; no further launch without new writes.
- Spurious done: `tx_done_tick` pulse while in IDLE with the FIFO empty → no state change and no `tx_start`.
